// File: rtl/serial_dft_bank.sv
// Streaming multi-channel single-bin DFT accumulator: one complex weight per
// in-frame sample index, two-stage multiply/accumulate, per-frame result.
module serial_dft_bank #(
    parameter int unsigned W_WIDTH      = 16,
    parameter int unsigned X_WIDTH      = 16,
    parameter int unsigned S_WIDTH      = 32,
    parameter int unsigned FRAME_LENGTH = 4,
    parameter int unsigned N_CH         = 2,
    parameter bit          SATURATE     = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  w_re,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  w_im,
    input  logic                                  valid_i,
    input  logic                                  sof_i,
    input  logic [N_CH-1:0][X_WIDTH-1:0]          x,
    output logic [N_CH-1:0][S_WIDTH-1:0]          re_o,
    output logic [N_CH-1:0][S_WIDTH-1:0]          im_o,
    output logic [N_CH-1:0]                       ovf_o,
    output logic                                  valid_o,
    output logic                                  resync_o
);

    localparam int unsigned P_W   = X_WIDTH + W_WIDTH;
    localparam int unsigned CNT_W = $clog2(FRAME_LENGTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LENGTH - 1);

    function automatic logic [P_W-1:0] f_mul(input logic [X_WIDTH-1:0] a,
                                             input logic [W_WIDTH-1:0] b);
        logic signed [P_W-1:0] ae;
        logic signed [P_W-1:0] be;
        ae = {{W_WIDTH{a[X_WIDTH-1]}}, a};
        be = {{X_WIDTH{b[W_WIDTH-1]}}, b};
        return ae * be;
    endfunction

    // Returns {overflow, next accumulator}; sum is formed one bit wider than S_WIDTH.
    function automatic logic [S_WIDTH:0] f_acc(input logic [S_WIDTH-1:0] acc,
                                               input logic [P_W-1:0]     prod,
                                               input logic               first);
        logic [S_WIDTH:0]   sum;
        logic [S_WIDTH-1:0] nxt;
        logic               ovf;
        sum = (first ? '0 : {acc[S_WIDTH-1], acc})
            + {{(S_WIDTH + 1 - P_W){prod[P_W-1]}}, prod};
        ovf = sum[S_WIDTH] ^ sum[S_WIDTH-1];
        nxt = sum[S_WIDTH-1:0];
        if (ovf && SATURATE) begin
            nxt = sum[S_WIDTH] ? {1'b1, {(S_WIDTH-1){1'b0}}} : {1'b0, {(S_WIDTH-1){1'b1}}};
        end
        return {ovf, nxt};
    endfunction

    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_idx;
    logic                          r_s1_valid;
    logic                          r_s1_first;
    logic                          r_s1_last;
    logic                          r_s1_resync;
    logic [N_CH-1:0][P_W-1:0]      r_p_re;
    logic [N_CH-1:0][P_W-1:0]      r_p_im;
    logic [N_CH-1:0][P_W-1:0]      w_p_re;
    logic [N_CH-1:0][P_W-1:0]      w_p_im;
    logic [N_CH-1:0][S_WIDTH-1:0]  r_acc_re;
    logic [N_CH-1:0][S_WIDTH-1:0]  r_acc_im;
    logic [N_CH-1:0][S_WIDTH:0]    w_res_re;
    logic [N_CH-1:0][S_WIDTH:0]    w_res_im;
    logic [N_CH-1:0]               r_ovf;
    logic [N_CH-1:0]               w_ovf;

    always_comb begin
        w_idx    = sof_i ? '0 : r_cnt;
        w_p_re   = '0;
        w_p_im   = '0;
        w_res_re = '0;
        w_res_im = '0;
        w_ovf    = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            w_p_re[c]   = f_mul(x[c], w_re[w_idx]);
            w_p_im[c]   = f_mul(x[c], w_im[w_idx]);
            w_res_re[c] = f_acc(r_acc_re[c], r_p_re[c], r_s1_first);
            w_res_im[c] = f_acc(r_acc_im[c], r_p_im[c], r_s1_first);
            // The first sample of a frame restarts the sticky flag.
            w_ovf[c]    = (r_s1_first ? 1'b0 : r_ovf[c])
                        | w_res_re[c][S_WIDTH] | w_res_im[c][S_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_resync <= 1'b0;
            r_p_re      <= '0;
            r_p_im      <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_ovf       <= '0;
            re_o        <= '0;
            im_o        <= '0;
            ovf_o       <= '0;
            valid_o     <= 1'b0;
            resync_o    <= 1'b0;
        end else begin
            r_s1_valid <= valid_i;
            valid_o    <= r_s1_valid && r_s1_last;
            resync_o   <= r_s1_valid && r_s1_resync;
            if (valid_i) begin
                r_cnt       <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
                r_s1_first  <= (w_idx == '0);
                r_s1_last   <= (w_idx == LAST_IDX);
                r_s1_resync <= sof_i && (r_cnt != '0);
                r_p_re      <= w_p_re;
                r_p_im      <= w_p_im;
            end
            if (r_s1_valid) begin
                for (int c = 0; c < int'(N_CH); c++) begin
                    r_acc_re[c] <= w_res_re[c][S_WIDTH-1:0];
                    r_acc_im[c] <= w_res_im[c][S_WIDTH-1:0];
                    if (r_s1_last) begin
                        re_o[c] <= w_res_re[c][S_WIDTH-1:0];
                        im_o[c] <= w_res_im[c][S_WIDTH-1:0];
                    end
                end
                r_ovf <= w_ovf;
                if (r_s1_last) begin
                    ovf_o <= w_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_dft_bank.sv
// Directed bench for serial_dft_bank: basic, back-to-back, gapped, resync,
// mid-frame reset and overflow (saturating and wrapping) scenarios.
module tb_serial_dft_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              valid_i;
    logic              sof_i;
    logic [3:0][15:0]  w_re;
    logic [3:0][15:0]  w_im;
    logic [1:0][15:0]  x;
    logic [1:0][31:0]  re_o;
    logic [1:0][31:0]  im_o;
    logic [1:0]        ovf_o;
    logic              valid_o;
    logic              resync_o;

    logic [3:0][7:0]   w8_re;
    logic [3:0][7:0]   w8_im;
    logic [0:0][7:0]   x8;
    logic [0:0][15:0]  s_re, s_im, r_re, r_im;
    logic [0:0]        s_ovf, r_ovf;
    logic              s_vo, s_rs, r_vo, r_rs;

    int total = 0;
    int bad   = 0;
    int n_vo  = 0;
    int n_rs  = 0;

    localparam logic [1:0][31:0] EXP_RE = {32'hFFFF_FFFC, 32'hFFFF_FFFC};
    localparam logic [1:0][31:0] EXP_IM = {32'd4, 32'd4};

    serial_dft_bank dut (
        .clk(clk), .rst(rst), .w_re(w_re), .w_im(w_im), .valid_i(valid_i), .sof_i(sof_i),
        .x(x), .re_o(re_o), .im_o(im_o), .ovf_o(ovf_o), .valid_o(valid_o), .resync_o(resync_o)
    );

    serial_dft_bank #(.W_WIDTH(8), .X_WIDTH(8), .S_WIDTH(16), .N_CH(1), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .w_re(w8_re), .w_im(w8_im), .valid_i(valid_i), .sof_i(sof_i),
        .x(x8), .re_o(s_re), .im_o(s_im), .ovf_o(s_ovf), .valid_o(s_vo), .resync_o(s_rs)
    );

    serial_dft_bank #(.W_WIDTH(8), .X_WIDTH(8), .S_WIDTH(16), .N_CH(1), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .w_re(w8_re), .w_im(w8_im), .valid_i(valid_i), .sof_i(sof_i),
        .x(x8), .re_o(r_re), .im_o(r_im), .ovf_o(r_ovf), .valid_o(r_vo), .resync_o(r_rs)
    );

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic drive(input logic v, input logic s, input int a, input int b);
        valid_i = v;
        sof_i   = s;
        x[0]    = 16'(a);
        x[1]    = 16'(b);
        @(posedge clk);
        #1;
        if (valid_o === 1'b1) n_vo++;
        if (resync_o === 1'b1) n_rs++;
    endtask

    task automatic send_basic(input logic sof0);
        drive(1'b1, sof0, 1, 2);
        drive(1'b1, 1'b0, 3, 4);
        drive(1'b1, 1'b0, 5, 6);
        drive(1'b1, 1'b0, 7, 8);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        total++;
        if (re_o !== '0 || im_o !== '0) begin
            bad++; $display("FAIL reset_data: re=%h im=%h want 0", re_o, im_o);
        end
        total++;
        if (ovf_o !== 2'b00 || valid_o !== 1'b0 || resync_o !== 1'b0) begin
            bad++; $display("FAIL reset_flags: ovf=%b vo=%b rs=%b want 0", ovf_o, valid_o, resync_o);
        end
    endtask

    task automatic test_basic;
        n_vo = 0;
        send_basic(1'b1);
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL basic_early: valid_o=%b want 0", valid_o);
        end
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (valid_o !== 1'b1) begin
            bad++; $display("FAIL basic_valid: valid_o=%b want 1", valid_o);
        end
        total++;
        if (re_o !== EXP_RE || im_o !== EXP_IM || ovf_o !== 2'b00) begin
            bad++; $display("FAIL basic_result: re=%h im=%h ovf=%b want %h %h 00",
                            re_o, im_o, ovf_o, EXP_RE, EXP_IM);
        end
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (valid_o !== 1'b0 || n_vo != 1 || re_o !== EXP_RE) begin
            bad++; $display("FAIL basic_hold: valid_o=%b pulses=%0d re=%h want 0 1 %h",
                            valid_o, n_vo, re_o, EXP_RE);
        end
    endtask

    task automatic test_back_to_back;
        int c0[9] = '{1, 3, 5, 7, 8, 6, 4, 2, 0};
        int c1[9] = '{2, 4, 6, 8, 1, 1, 1, 1, 0};
        logic [8:0] seen = '0;
        for (int k = 0; k < 9; k++) begin
            drive(k < 8, (k == 0) || (k == 4), c0[k], c1[k]);
            seen[k] = valid_o;
            if (k == 6) begin
                total++;
                if (re_o !== EXP_RE || im_o !== EXP_IM) begin
                    bad++; $display("FAIL b2b_hold: re=%h im=%h want %h %h",
                                    re_o, im_o, EXP_RE, EXP_IM);
                end
            end
        end
        total++;
        if (seen !== 9'b1_0001_0000) begin
            bad++; $display("FAIL b2b_timing: pulses=%b want 100010000", seen);
        end
        total++;
        if (re_o !== {32'd0, 32'd4} || im_o !== {32'd0, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL b2b_result: re=%h im=%h want 0/4 0/-4", re_o, im_o);
        end
    endtask

    task automatic test_gaps;
        int c0[4] = '{1, 3, 5, 7};
        int c1[4] = '{2, 4, 6, 8};
        int gap[4] = '{2, 0, 3, 0};
        n_vo = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, c0[i], c1[i]);
            for (int g = 0; g < gap[i]; g++) drive(1'b0, 1'b0, 99, 99);
        end
        total++;
        if (n_vo != 0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL gap_early: pulses=%0d valid_o=%b want 0 0", n_vo, valid_o);
        end
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (valid_o !== 1'b1 || re_o !== EXP_RE || im_o !== EXP_IM) begin
            bad++; $display("FAIL gap_result: vo=%b re=%h im=%h want 1 %h %h",
                            valid_o, re_o, im_o, EXP_RE, EXP_IM);
        end
    endtask

    task automatic test_resync;
        n_vo = 0;
        n_rs = 0;
        drive(1'b1, 1'b1, 100, -50);
        drive(1'b1, 1'b0, 100, -50);
        drive(1'b1, 1'b1, 1, 2);
        total++;
        if (resync_o !== 1'b0) begin
            bad++; $display("FAIL resync_early: resync_o=%b want 0", resync_o);
        end
        drive(1'b1, 1'b0, 3, 4);
        total++;
        if (resync_o !== 1'b1) begin
            bad++; $display("FAIL resync_pulse: resync_o=%b want 1", resync_o);
        end
        drive(1'b1, 1'b0, 5, 6);
        drive(1'b1, 1'b0, 7, 8);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (valid_o !== 1'b1 || re_o !== EXP_RE || im_o !== EXP_IM) begin
            bad++; $display("FAIL resync_result: vo=%b re=%h im=%h want 1 %h %h",
                            valid_o, re_o, im_o, EXP_RE, EXP_IM);
        end
        total++;
        if (n_vo != 1 || n_rs != 1) begin
            bad++; $display("FAIL resync_count: valid=%0d resync=%0d want 1 1", n_vo, n_rs);
        end
    endtask

    task automatic test_reset_mid;
        n_vo = 0;
        drive(1'b1, 1'b1, 9, 9);
        drive(1'b1, 1'b0, 9, 9);
        rst = 1'b1;
        drive(1'b1, 1'b0, 9, 9);
        rst = 1'b0;
        total++;
        if (re_o !== '0 || im_o !== '0 || ovf_o !== 2'b00 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_clear: re=%h im=%h ovf=%b vo=%b want 0",
                            re_o, im_o, ovf_o, valid_o);
        end
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (n_vo != 0) begin
            bad++; $display("FAIL rstmid_novalid: pulses=%0d want 0", n_vo);
        end
        send_basic(1'b0);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (valid_o !== 1'b1 || re_o !== EXP_RE || im_o !== EXP_IM) begin
            bad++; $display("FAIL rstmid_result: vo=%b re=%h im=%h want 1 %h %h",
                            valid_o, re_o, im_o, EXP_RE, EXP_IM);
        end
    endtask

    task automatic test_overflow;
        x8[0] = 8'd127;
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (s_vo !== 1'b1 || s_re[0] !== 16'h7FFF || s_im[0] !== 16'h0000 || s_ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_sat: vo=%b re=%h im=%h ovf=%b want 1 7fff 0000 1",
                            s_vo, s_re, s_im, s_ovf);
        end
        total++;
        if (r_re[0] !== 16'hFC04 || r_ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_wrap: re=%h ovf=%b want fc04 1", r_re, r_ovf);
        end
        x8[0] = 8'd1;
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (s_re[0] !== 16'd508 || s_ovf !== 1'b0 || r_re[0] !== 16'd508 || r_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_clean: sat=%h/%b wrap=%h/%b want 01fc/0 01fc/0",
                            s_re, s_ovf, r_re, r_ovf);
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        x       = '0;
        x8      = '0;
        w_re    = {16'd0, 16'hFFFF, 16'd0, 16'd1};
        w_im    = {16'd1, 16'd0, 16'hFFFF, 16'd0};
        w8_re   = {8'd127, 8'd127, 8'd127, 8'd127};
        w8_im   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_resync();
        test_reset_mid();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_dft_bank.md
# serial_dft_bank

Streaming multi-channel single-bin DFT accumulator. Accepts N_CH real samples per cycle. Multiplies each sample by the complex weight selected by the in-frame sample index and accumulates over FRAME_LENGTH accepted samples. Presents one complex result per channel per frame. It is the parametrised successor to the two-channel serial FFT coral: it adds arbitrary channel count, input gaps, frame resync, and saturating accumulation with overflow flags. It sits between the sample front-end and the spectral post-processing.

## Interface

- W_WIDTH, 16, signed weight width
- X_WIDTH, 16, signed sample width
- S_WIDTH, 32, signed result width; X_WIDTH+W_WIDTH <= S_WIDTH required
- FRAME_LENGTH, 4, samples per frame, >= 2
- N_CH, 2, parallel channels, >= 1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- w_re  in  [FRAME_LENGTH][W_WIDTH]  signed real weights, index = sample index; static during operation
- w_im  in  [FRAME_LENGTH][W_WIDTH]  signed imaginary weights
- valid_i  in  1  sample qualifier
- sof_i  in  1  start of frame, meaningful only with valid_i
- x  in  [N_CH][X_WIDTH]  signed samples, one per channel
- re_o  out  [N_CH][S_WIDTH]  signed real result per channel
- im_o  out  [N_CH][S_WIDTH]  signed imaginary result per channel
- ovf_o  out  [N_CH]  per-channel overflow flag for the presented frame (re or im)
- valid_o  out  1  one-cycle pulse, results updated
- resync_o  out  1  one-cycle pulse, partial frame discarded by sof_i

## Operation

- Sample counter cnt runs 0..FRAME_LENGTH-1. It advances only on accepted samples (valid_i=1) and wraps to 0 after FRAME_LENGTH-1. valid_i=0 cycles are gaps: no state change, no limit on gap length.
- Stage 1, at the accept edge: register the products x[c]*w_re[idx] and x[c]*w_im[idx], each X_WIDTH+W_WIDTH bits and signed. Also register the tags first = (idx==0) and last = (idx==FRAME_LENGTH-1). idx = 0 if sof_i else cnt.
- Stage 2, one edge later, only when the stage-1 valid is set:
  - sum = (first ? 0 : acc) + sign-extended product, computed in S_WIDTH+1 bits.
  - If sum is outside the S_WIDTH range, set the sticky per-channel ovf. With SATURATE=1, acc takes the clamped value (+2^(S_WIDTH-1)-1 or -2^(S_WIDTH-1)). With SATURATE=0, acc takes the low S_WIDTH bits.
  - first clears the sticky ovf before this sample's check.
  - On last: load re_o, im_o and ovf_o from the new acc and ovf values, and pulse valid_o.
- sof_i with valid_i while cnt != 0: the partial frame is discarded with no valid_o. resync_o pulses. The sample becomes index 0 and cnt is set to 1. sof_i while cnt == 0 is a normal frame start with no resync_o.
- Outputs hold their values between valid_o pulses.
- Back-to-back frames run without bubbles. Frame N+1's index-0 sample may follow frame N's last sample on the next cycle.

## Timing

- Reset values: re_o=0, im_o=0, ovf_o=0, valid_o=0, resync_o=0, cnt=0. Pipeline valid bits and accumulators are cleared.
- Latency: the last sample is accepted at edge t. re_o, im_o, ovf_o and valid_o=1 update at edge t+1. valid_o returns to 0 at edge t+2 unless another frame also ends there, which is only possible when FRAME_LENGTH... never, since FRAME_LENGTH >= 2.
- resync_o goes high at the edge after the sof_i accept edge and lasts one cycle.
- rst mid-frame: the partial frame and any in-flight stage-1 product are discarded, with no valid_o. The next accepted sample is index 0.
- rst has priority over valid_i and sof_i in the same cycle.
- Weights must be stable from the accept edge of index 0 through the accept edge of the last sample.

## Test plan

Defaults unless noted: FRAME_LENGTH=4, N_CH=2, w_re={1,0,-1,0}, w_im={0,-1,0,1}.

- Basic frame: ch0 = 1,3,5,7 and ch1 = 2,4,6,8 on 4 consecutive cycles -> one valid_o pulse one edge after the 4th sample, with re_o={-4,-4}, im_o={4,4}, ovf_o=0.
- Back-to-back frames: basic frame, then immediately ch0 = 8,6,4,2 and ch1 = 1,1,1,1 -> second valid_o exactly 4 cycles after the first, with ch0 re=4, im=-4 and ch1 re=0, im=0. The first results hold in between.
- Gapped input: basic frame with 0-3 idle cycles between samples -> identical results, valid_o one edge after the last accepted sample, no pulse during gaps.
- Overflow: X_WIDTH=8, W_WIDTH=8, S_WIDTH=16, w_re all 127, w_im all 0, x=127 on 4 samples:
  - SATURATE=1 -> re_o=32767, im_o=0, ovf_o=1.
  - SATURATE=0 -> re_o=-1020, ovf_o=1.
  - The next clean frame gives ovf_o=0.
- Resync: send 2 samples, then sof_i with the basic frame -> resync_o pulses once, only one valid_o, results -4/4.
- Reset: rst for 1 cycle after 2 samples -> all outputs 0, no valid_o. A following basic frame gives the correct -4/4 results.
